// File: rtl/if_stream_fifo.sv
// if_stream_fifo: first-word-fall-through buffer for the input-feature stream.
// Each entry holds {row_start, row_end, data}; the head entry is always
// presented on dout and popped with ren. Pointers carry a wrap bit so that
// full/empty stay unambiguous at any occupancy.
// Optional build macro: IF_FIFO_ROW_COUNT_EN adds the rows_avail output
// (number of buffered words carrying the row-end flag).
module if_stream_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_LEN   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  wen,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_start,
   input  logic                  din_end,
   output logic                  full,
   input  logic                  ren,
   output logic [DATA_WIDTH+1:0] dout,
   output logic                  empty,
   output logic [ADDR_LEN:0]     count,
   output logic                  overflow,
   output logic                  underflow
`ifdef IF_FIFO_ROW_COUNT_EN
   ,
   output logic [ADDR_LEN:0]     rows_avail
`endif
);

   localparam logic [ADDR_LEN:0] PTR_ONE = 1;

   logic [DATA_WIDTH+1:0] mem_q [DEPTH];

   logic [ADDR_LEN:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_LEN:0] rd_ptr_q, rd_ptr_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic              empty_w;
   logic              full_w;
   logic              wr_acc;
   logic              rd_acc;
   logic [DATA_WIDTH+1:0] head_w;

   // Status flags, head word and transfer-acceptance decode.
   always_comb begin
      empty_w = (wr_ptr_q == rd_ptr_q);
      full_w  = (wr_ptr_q[ADDR_LEN-1:0] == rd_ptr_q[ADDR_LEN-1:0]) &&
                (wr_ptr_q[ADDR_LEN] != rd_ptr_q[ADDR_LEN]);
      head_w  = mem_q[rd_ptr_q[ADDR_LEN-1:0]];
      // A pop while full frees the slot the concurrent write lands in.
      wr_acc  = wen && (!full_w || ren) && !clr;
      rd_acc  = ren && !empty_w && !clr;
   end

   // Next-state for pointers and sticky error flags; clr overrides everything.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (clr) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (wen && full_w && !ren) overflow_d = 1'b1;
         if (ren && empty_w) underflow_d = 1'b1;
      end
   end

   // Pointer and flag registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage array; contents are never reset, only made unreachable.
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q[ADDR_LEN-1:0]] <= {din_start, din_end, din};
   end

`ifdef IF_FIFO_ROW_COUNT_EN
   logic [ADDR_LEN:0] rows_q, rows_d;

   // Track buffered row-end words: +1 on an end-flagged write, -1 on an end-flagged pop.
   always_comb begin
      rows_d = rows_q;
      if (clr) begin
         rows_d = '0;
      end else begin
         if (wr_acc && din_end && !(rd_acc && head_w[DATA_WIDTH]))
            rows_d = rows_q + PTR_ONE;
         else if (rd_acc && head_w[DATA_WIDTH] && !(wr_acc && din_end))
            rows_d = rows_q - PTR_ONE;
      end
   end

   // Row counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rows_q <= '0;
      else     rows_q <= rows_d;
   end

   assign rows_avail = rows_q;
`endif

   assign full      = full_w;
   assign empty     = empty_w;
   assign dout      = head_w;
   assign count     = wr_ptr_q - rd_ptr_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: doc/if_stream_fifo.md
Name: if_stream_fifo

Overview:
- Input-feature stream buffer directly upstream of the PE datapath's IF read logic.
- Stores feature words tagged with row-start/row-end markers, presented first-word-fall-through.
- The datapath samples the head word combinationally and pops it with a read strobe.
- Provides the empty flag the IF reader stalls on, and full/count to the upstream loader.

Parameters:
- DATA_WIDTH, 8, feature word width (equals the datapath's IF scratch width).
- DEPTH, 16, number of entries; power of two, at least 2.
- ADDR_LEN, 4, log2(DEPTH); pointer width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous flush: pointers and count go to 0, data is not cleared.
- wen  input  1  write request from the upstream loader.
- din  input  DATA_WIDTH  feature word.
- din_start  input  1  word is the first word of a row.
- din_end  input  1  word is the last word of a row.
- full  output  1  no free entry.
- ren  input  1  pop the head word (driven by the datapath's IF buffer read).
- dout  output  DATA_WIDTH+2  head word: [DATA_WIDTH-1:0] data, [DATA_WIDTH] end flag, [DATA_WIDTH+1] start flag.
- empty  output  1  no valid entry; dout is don't-care.
- count  output  ADDR_LEN+1  occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was dropped.
- underflow  output  1  sticky: a read was issued while empty.

Behaviour:
- Storage: DEPTH x (DATA_WIDTH+2) register array.
- Pointers: wr_ptr and rd_ptr, ADDR_LEN+1 bits each, with wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = (address bits equal) and (wrap bits differ).
- count = wr_ptr - rd_ptr, modulo 2^(ADDR_LEN+1).
- Reset values: pointers 0, count 0, empty 1, full 0, overflow 0, underflow 0. dout is don't-care while empty; the implementation drives mem[rd_ptr].
- FWFT: dout = mem[rd_ptr[ADDR_LEN-1:0]] combinationally.
  - A word written at edge N is visible on dout and empty deasserts after edge N, i.e. one-cycle write-to-read latency.
- Write accepted iff wen and (!full or ren). On acceptance: mem[wr_ptr] <= {din_start, din_end, din}; wr_ptr increments.
- Read accepted iff ren and !empty. On acceptance: rd_ptr increments.
- Simultaneous read and write:
  - Not empty, not full: both happen; count unchanged.
  - Full: both happen; full stays 1 and the new word lands in the freed slot.
  - Empty: the write happens; the read is ignored and underflow sets. No bypass: the written word appears next cycle.
- wen while full without ren: write dropped, overflow <= 1, no state change.
- ren while empty: no pointer change, underflow <= 1.
- Wrap-around: pointers wrap naturally modulo 2^(ADDR_LEN+1); full and empty stay correct across any number of wraps.
- clr:
  - Takes priority over wen and ren in the same cycle; both are ignored.
  - Clears pointers and both sticky flags.
  - Next cycle: empty = 1, count = 0.
- Async rst mid-operation: all state goes to reset values immediately. Data already in the array is unreachable after reset.
- Start and end flags are stored and returned verbatim; the FIFO does no row validation. A single-word row with both flags set is legal.

Optional Feature:
- Macro: IF_FIFO_ROW_COUNT_EN.
- Defined: adds output rows_avail [ADDR_LEN:0], the number of stored words with end flag = 1.
  - +1 on an accepted write with din_end = 1.
  - -1 on an accepted read whose head has end flag = 1.
  - Both in the same cycle leave it unchanged.
  - Reset and clr set it to 0.
  - Lets the IF reader start a row only when the whole row is buffered.
- Not defined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then write 0x11 (start=1), 0x22, 0x33 (end=1) on consecutive cycles, then ren for 3 cycles -> dout shows 0x211, 0x022, 0x133 in order; empty = 1 and count = 0 afterwards.
- Write 16 words 0x00..0x0F without reads, then write 0xAA -> full = 1 and count = 16 after the 16th; 0xAA is dropped; overflow = 1; reads return 0x00..0x0F.
- With FIFO full, assert wen (0x55) and ren together for one cycle -> count stays 16, full stays 1, head advances to 0x01, and 0x55 is read last.
- With FIFO empty, assert ren alone -> underflow = 1, count = 0. Then wen + ren together with 0x77 -> underflow stays set; next cycle empty = 0, dout[7:0] = 0x77, count = 1.
- Run 40 write/read pairs with occupancy held at 3, forcing two or more pointer wraps, then flush with clr while wen and ren are high -> data order is intact throughout; after clr, empty = 1, count = 0, overflow = 0, underflow = 0.
- IF_FIFO_ROW_COUNT_EN defined: write rows of lengths 3 and 2 -> rows_avail = 2. Pop 3 words -> rows_avail = 1. Assert rst asynchronously mid-clock -> rows_avail = 0 and empty = 1 before the next edge.
